// File: rtl/pipe_control.sv
// pipe_control: ID-stage control decode carried through ID/EX, EX/MEM and MEM/WB,
// with stall bubbles, branch-flush squash and a saturating illegal-opcode counter.
module pipe_control #(
   parameter int OPCODE_W     = 7,
   parameter int ALUOP_W      = 2,
   parameter int ENABLE_ITYPE = 1,
   parameter int ILL_CNT_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [OPCODE_W-1:0]  id_opcode,
   input  logic                 id_valid,
   input  logic                 stall,
   input  logic                 flush,
   output logic [ALUOP_W-1:0]   ex_alu_op,
   output logic                 ex_alu_src,
   output logic                 ex_mem_read,
   output logic                 ex_reg_write,
   output logic                 mem_branch,
   output logic                 mem_mem_read,
   output logic                 mem_mem_write,
   output logic                 mem_reg_write,
   output logic                 wb_reg_write,
   output logic                 wb_mem_to_reg,
   output logic                 illegal_op,
   output logic [ILL_CNT_W-1:0] illegal_count
);
   typedef struct packed {
      logic [ALUOP_W-1:0] alu_op;
      logic               alu_src;
      logic               mem_read;
      logic               mem_write;
      logic               branch;
      logic               reg_write;
      logic               mem_to_reg;
   } ctrl_t;
   ctrl_t dec, id_ex, ex_mem, mem_wb;
   logic is_r, is_i, is_ld, is_sd, is_beq, illegal, count_ill;
   assign is_r   = id_valid && id_opcode == OPCODE_W'(7'b0110011);
   assign is_i   = id_valid && ENABLE_ITYPE != 0 && id_opcode == OPCODE_W'(7'b0010011);
   assign is_ld  = id_valid && id_opcode == OPCODE_W'(7'b0000011);
   assign is_sd  = id_valid && id_opcode == OPCODE_W'(7'b0100011);
   assign is_beq = id_valid && id_opcode == OPCODE_W'(7'b1100011);
   assign illegal   = id_valid && !(is_r || is_i || is_ld || is_sd || is_beq);
   // only an illegal instruction that actually enters EX is counted
   assign count_ill = illegal && !stall && !flush;
   always_comb begin
      dec            = ctrl_t'(0);
      dec.alu_op     = is_r ? ALUOP_W'(2) : is_i ? ALUOP_W'(3) : is_beq ? ALUOP_W'(1) : ALUOP_W'(0);
      dec.alu_src    = is_i || is_ld || is_sd;
      dec.mem_read   = is_ld;
      dec.mem_write  = is_sd;
      dec.branch     = is_beq;
      dec.reg_write  = is_r || is_i || is_ld;
      dec.mem_to_reg = is_ld;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_ex         <= ctrl_t'(0);
         ex_mem        <= ctrl_t'(0);
         mem_wb        <= ctrl_t'(0);
         illegal_op    <= 1'b0;
         illegal_count <= '0;
      end else begin
         id_ex      <= (flush || stall) ? ctrl_t'(0) : dec;
         ex_mem     <= flush ? ctrl_t'(0) : id_ex;
         mem_wb     <= ex_mem;
         illegal_op <= count_ill;
         if (count_ill && illegal_count != '1)
            illegal_count <= illegal_count + ILL_CNT_W'(1);
      end
   end
   assign ex_alu_op     = id_ex.alu_op;
   assign ex_alu_src    = id_ex.alu_src;
   assign ex_mem_read   = id_ex.mem_read;
   assign ex_reg_write  = id_ex.reg_write;
   assign mem_branch    = ex_mem.branch;
   assign mem_mem_read  = ex_mem.mem_read;
   assign mem_mem_write = ex_mem.mem_write;
   assign mem_reg_write = ex_mem.reg_write;
   assign wb_reg_write  = mem_wb.reg_write;
   assign wb_mem_to_reg = mem_wb.mem_to_reg;
endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: directed checks of decode, pipeline timing, stall/flush,
// illegal-opcode counting and asynchronous reset, with I-type on and off.
module tb_pipe_control;
   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                          OP_SD = 7'b0100011, OP_BEQ = 7'b1100011, OP_BAD = 7'b1111111;
   logic clk = 1'b0, rst_n = 1'b0, id_valid = 1'b0, stall = 1'b0, flush = 1'b0;
   logic [6:0] id_opcode = '0;
   logic [1:0] ex_alu_op, ex_alu_op0;
   logic ex_alu_src, ex_mem_read, ex_reg_write, mem_branch, mem_mem_read, mem_mem_write;
   logic mem_reg_write, wb_reg_write, wb_mem_to_reg, illegal_op;
   logic ex_alu_src0, ex_mem_read0, ex_reg_write0, mem_branch0, mem_mem_read0, mem_mem_write0;
   logic mem_reg_write0, wb_reg_write0, wb_mem_to_reg0, illegal_op0;
   logic [7:0] illegal_count, illegal_count0;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   pipe_control dut (
      .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_valid(id_valid), .stall(stall), .flush(flush),
      .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
      .mem_branch(mem_branch), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
      .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
      .illegal_op(illegal_op), .illegal_count(illegal_count));
   pipe_control #(.ENABLE_ITYPE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_valid(id_valid), .stall(stall), .flush(flush),
      .ex_alu_op(ex_alu_op0), .ex_alu_src(ex_alu_src0), .ex_mem_read(ex_mem_read0), .ex_reg_write(ex_reg_write0),
      .mem_branch(mem_branch0), .mem_mem_read(mem_mem_read0), .mem_mem_write(mem_mem_write0),
      .mem_reg_write(mem_reg_write0), .wb_reg_write(wb_reg_write0), .wb_mem_to_reg(wb_mem_to_reg0),
      .illegal_op(illegal_op0), .illegal_count(illegal_count0));
   wire [19:0] all_out  = {ex_alu_op, ex_alu_src, ex_mem_read, ex_reg_write, mem_branch, mem_mem_read,
                           mem_mem_write, mem_reg_write, wb_reg_write, wb_mem_to_reg, illegal_op, illegal_count};
   wire [19:0] all_out0 = {ex_alu_op0, ex_alu_src0, ex_mem_read0, ex_reg_write0, mem_branch0, mem_mem_read0,
                           mem_mem_write0, mem_reg_write0, wb_reg_write0, wb_mem_to_reg0, illegal_op0, illegal_count0};
   wire [4:0] ex_bits  = {ex_alu_op, ex_alu_src, ex_mem_read, ex_reg_write};
   wire [3:0] mem_bits = {mem_branch, mem_mem_read, mem_mem_write, mem_reg_write};
   wire [4:0] ex_bits0 = {ex_alu_op0, ex_alu_src0, ex_mem_read0, ex_reg_write0};
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic v, input logic [6:0] op, input logic s, input logic f);
      id_valid = v; id_opcode = op; stall = s; flush = f;
   endtask
   initial begin
      #1;
      chk("reset_all", all_out, 0);
      chk("reset_all0", all_out0, 0);
      tick(); tick();
      rst_n = 1'b1;
      // load flows through EX, MEM, WB
      drive(1, OP_LD, 0, 0); tick();
      chk("ld_ex", ex_bits, 5'b00_1_1_1);
      drive(0, OP_LD, 0, 0); tick();
      chk("ld_mem", mem_bits, 4'b0101);
      chk("ld_ex_bubble", ex_bits, 0);
      tick();
      chk("ld_wb", {wb_reg_write, wb_mem_to_reg}, 2'b11);
      // R-type then I-ALU, I-type enabled and disabled
      drive(1, OP_R, 0, 0); tick();
      chk("r_ex", ex_bits, 5'b10_0_0_1);
      chk("r_ex0", ex_bits0, 5'b10_0_0_1);
      drive(1, OP_I, 0, 0); tick();
      chk("i_ex", ex_bits, 5'b11_1_0_1);
      chk("i_no_ill", {illegal_op, illegal_count}, 9'h000);
      chk("i_ex0_bubble", ex_bits0, 0);
      chk("i_ill0", {illegal_op0, illegal_count0}, 9'h101);
      drive(0, OP_I, 0, 0); tick();
      chk("ill0_pulse_end", {illegal_op0, illegal_count0}, 9'h001);
      // beq in MEM flushes sd in EX and ld in ID
      tick(); tick();
      drive(1, OP_BEQ, 0, 0); tick();
      chk("beq_ex", ex_bits, 5'b01_0_0_0);
      drive(1, OP_SD, 0, 0); tick();
      chk("sd_ex", ex_bits, 5'b00_1_0_0);
      chk("beq_mem", mem_bits, 4'b1000);
      drive(1, OP_LD, 0, 1); tick();
      chk("flush_ex", ex_bits, 0);
      chk("flush_mem", mem_bits, 0);
      chk("flush_wb", {wb_reg_write, wb_mem_to_reg}, 0);
      // illegal under flush, and under stall+flush, is not counted
      drive(1, OP_BAD, 0, 1); tick();
      chk("flush_ill", {illegal_op, illegal_count}, 9'h000);
      drive(1, OP_BAD, 1, 1); tick();
      chk("stallflush_ill", {illegal_op, illegal_count}, 9'h000);
      chk("stallflush_ex", ex_bits, 0);
      // load-use stall
      drive(1, OP_LD, 0, 0); tick();
      drive(1, OP_R, 1, 0); tick();
      chk("stall_ex", ex_bits, 0);
      chk("stall_ld_mem", mem_bits, 4'b0101);
      drive(1, OP_R, 0, 0); tick();
      chk("after_stall_ex", ex_bits, 5'b10_0_0_1);
      chk("stall_bubble_mem", mem_bits, 0);
      // saturating illegal counter
      drive(1, OP_BAD, 1, 0); tick();
      chk("bad_stall", {illegal_op, illegal_count}, 9'h000);
      drive(1, OP_BAD, 0, 0); tick();
      chk("bad_first", {illegal_op, illegal_count}, 9'h101);
      chk("bad_first_ex", ex_bits, 0);
      for (int i = 0; i < 299; i++) tick();
      chk("bad_sat", {illegal_op, illegal_count}, 9'h1ff);
      chk("bad_sat0", illegal_count0, 8'hff);
      drive(1, OP_BAD, 1, 0); tick();
      chk("bad_sat_stall", {illegal_op, illegal_count}, 9'h0ff);
      // asynchronous reset with ld in MEM
      drive(1, OP_LD, 0, 0); tick();
      drive(0, OP_LD, 0, 0); tick();
      chk("pre_rst_mem", mem_bits, 4'b0101);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst", all_out, 0);
      chk("async_rst0", all_out0, 0);
      #2 rst_n = 1'b1;
      tick();
      chk("post_rst", all_out, 0);
      drive(1, OP_R, 0, 0); tick();
      chk("restart_ex", ex_bits, 5'b10_0_0_1);
      drive(0, OP_R, 0, 0); tick();
      chk("restart_mem", mem_bits, 4'b0001);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_control.md
Name: pipe_control

Overview:
- Parametrised successor to the single-cycle control decoder. Decodes the ID-stage opcode and carries the control bits through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 8-bit RISC-V pipeline.
- Adds I-type ALU decode, bubble insertion on stall, squash on branch flush, and a saturating illegal-opcode counter.
- Sits between the IF/ID register and the datapath. The hazard unit drives its stall input; branch resolution in MEM drives its flush input.

Parameters:
- OPCODE_W, 7, opcode field width.
- ALUOP_W, 2, ALU-op encoding width; must be at least 2.
- ENABLE_ITYPE, 1. When 1, opcode 0010011 decodes as I-type ALU. When 0, that opcode is illegal.
- ILL_CNT_W, 8, width of the illegal-opcode counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_opcode  in  OPCODE_W  opcode of the instruction in ID
- id_valid  in  1  ID holds a real instruction
- stall  in  1  hazard unit: insert bubble into ID/EX
- flush  in  1  branch taken in MEM: squash ID/EX and EX/MEM inputs
- ex_alu_op  out  ALUOP_W  ALU-op for EX
- ex_alu_src  out  1  0 = rs2, 1 = immediate
- ex_mem_read  out  1  load in EX (for load-use detection)
- ex_reg_write  out  1  EX writes rd (for forwarding)
- mem_branch  out  1  beq in MEM
- mem_mem_read  out  1  data-memory read
- mem_mem_write  out  1  data-memory write
- mem_reg_write  out  1  MEM writes rd (for forwarding)
- wb_reg_write  out  1  register-file write enable
- wb_mem_to_reg  out  1  1 = memory data, 0 = ALU result
- illegal_op  out  1  one-cycle pulse, registered
- illegal_count  out  ILL_CNT_W  saturating count of illegal opcodes

Behaviour:
- Decode is combinational from id_opcode. id_valid=0 forces the all-zero bubble.
- R-type 0110011: reg_write=1, alu_op=10, all other bits 0.
- I-ALU 0010011 (ENABLE_ITYPE=1): reg_write=1, alu_src=1, alu_op=11.
- ld 0000011: alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, alu_op=00.
- sd 0100011: alu_src=1, mem_write=1, alu_op=00, mem_to_reg=0.
- beq 1100011: branch=1, alu_op=01, mem_to_reg=0.
- No X is ever driven. Don't-care bits are 0.
- Any other opcode with id_valid=1 is illegal:
  - decodes to a bubble;
  - registers illegal_op=1 for one cycle;
  - increments illegal_count, which saturates at all-ones and does not wrap.
- Pipeline timing: an opcode present in cycle n appears on ex_* at n+1, mem_* at n+2, wb_* at n+3. EX/MEM and MEM/WB advance every cycle.
- ID/EX load priority:
  1. flush → bubble
  2. stall → bubble
  3. otherwise → decoded bits
- Flush also loads a bubble into EX/MEM instead of the ID/EX contents. MEM/WB is unaffected, so the branch itself retires.
- An illegal opcode coinciding with stall or flush does not count and does not pulse. Only an instruction actually entering EX is counted.
- Simultaneous stall and flush: flush wins; result is identical to flush alone.
- Reset (asynchronous, active-low, effective mid-operation):
  - every pipeline register clears to bubble;
  - all outputs go to 0, including illegal_op=0 and illegal_count=0;
  - release takes effect at the next rising edge.

Test Plan:
- ld (0000011) at cycle 0, no stall → cycle1: ex_alu_src=1, ex_mem_read=1; cycle2: mem_mem_read=1; cycle3: wb_reg_write=1, wb_mem_to_reg=1.
- R-type then I-ALU back-to-back → ex_alu_op=10 then 11, with ex_alu_src=0 then 1. Repeat with ENABLE_ITYPE=0 → second instruction gives an illegal_op pulse and all-zero controls.
- beq in MEM with flush=1 while sd sits in EX and ld in ID → next cycle: mem_mem_write=0, ex_mem_read=0; wb_* of the beq unchanged.
- Load-use: stall=1 for one cycle with R-type in ID → ex_* all 0 that cycle; the R-type appears on ex_alu_op=10 the following cycle.
- Present opcode 1111111 valid for 300 cycles with ILL_CNT_W=8 → illegal_count reaches 255 and holds. Pulse suppressed in cycles where stall=1.
- Assert rst_n=0 mid-stream with ld in MEM → all outputs 0 immediately without a clock edge; clean restart on release.
